// File: rtl/cm3_sys_ctrl.sv
`timescale 1ns/1ps
// cm3_sys_ctrl: Cortex-M3 system controller -- CPU reset sequencing, debug power-up
// handshake and external IRQ synchronisation onto INTISR.
module cm3_sys_ctrl #(
  parameter int unsigned        NUM_IRQ       = 16,
  parameter int unsigned        SYNC_STAGES   = 2,
  parameter logic [NUM_IRQ-1:0] IRQ_EDGE      = '0,
  parameter int unsigned        POR_CYCLES    = 16,
  parameter int unsigned        SYSRST_CYCLES = 8,
  parameter int unsigned        DBG_ACK_DLY   = 1,
  parameter bit                 LOCKUP_RST    = 1'b0
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               sysresetreq,
  input  logic               lockup,
  input  logic               cdbg_pwr_up_req,
  output logic               cdbg_pwr_up_ack,
  input  logic [NUM_IRQ-1:0] ext_irq,
  output logic [239:0]       intisr,
  output logic               cpu_rstn,
  output logic [1:0]         rst_cause
);

  localparam int unsigned CNT_MAX = (POR_CYCLES > SYSRST_CYCLES) ? POR_CYCLES : SYSRST_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned DBG_W   = $clog2(DBG_ACK_DLY + 1);

  localparam logic [CNT_W-1:0] POR_LAST = CNT_W'(POR_CYCLES - 1);
  localparam logic [CNT_W-1:0] SYS_LAST = CNT_W'(SYSRST_CYCLES - 1);
  localparam logic [DBG_W-1:0] DBG_LAST = DBG_W'(DBG_ACK_DLY - 1);

  localparam logic [1:0] CAUSE_POR    = 2'b00;
  localparam logic [1:0] CAUSE_SYSREQ = 2'b01;
  localparam logic [1:0] CAUSE_LOCKUP = 2'b10;

  typedef enum logic [1:0] {
    POR_HOLD = 2'd0,
    RUN      = 2'd1,
    SYSRST   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cpu_rstn_d;
  logic [1:0]       cause_d;

  // Reset sequencer state and registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= POR_HOLD;
      cnt_q     <= '0;
      cpu_rstn  <= 1'b0;
      rst_cause <= CAUSE_POR;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cpu_rstn  <= cpu_rstn_d;
      rst_cause <= cause_d;
    end
  end

  // Reset sequencer next-state; the SYSRST counter saturates while the core still requests reset
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cpu_rstn_d = cpu_rstn;
    cause_d    = rst_cause;
    case (state_q)
      POR_HOLD: begin
        cpu_rstn_d = 1'b0;
        if (cnt_q == POR_LAST) begin
          state_d    = RUN;
          cnt_d      = '0;
          cpu_rstn_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        cpu_rstn_d = 1'b1;
        if (sysresetreq) begin
          state_d    = SYSRST;
          cnt_d      = '0;
          cpu_rstn_d = 1'b0;
          cause_d    = CAUSE_SYSREQ;
        end else if (LOCKUP_RST && lockup) begin
          state_d    = SYSRST;
          cnt_d      = '0;
          cpu_rstn_d = 1'b0;
          cause_d    = CAUSE_LOCKUP;
        end
      end
      SYSRST: begin
        cpu_rstn_d = 1'b0;
        if (cnt_q == SYS_LAST) begin
          if (!sysresetreq) begin
            state_d    = RUN;
            cnt_d      = '0;
            cpu_rstn_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d    = POR_HOLD;
        cnt_d      = '0;
        cpu_rstn_d = 1'b0;
      end
    endcase
  end

  logic [DBG_W-1:0] dbg_cnt_q;

  // Debug power-up handshake: ack after DBG_ACK_DLY consecutive high samples of req
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dbg_cnt_q       <= '0;
      cdbg_pwr_up_ack <= 1'b0;
    end else if (!cdbg_pwr_up_req) begin
      dbg_cnt_q       <= '0;
      cdbg_pwr_up_ack <= 1'b0;
    end else if (!cdbg_pwr_up_ack) begin
      dbg_cnt_q <= dbg_cnt_q + DBG_W'(1);
      if (dbg_cnt_q == DBG_LAST) begin
        cdbg_pwr_up_ack <= 1'b1;
      end
    end
  end

  logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] sync_q;
  logic [NUM_IRQ-1:0]                  synced;
  logic [NUM_IRQ-1:0]                  s_d;
  logic [NUM_IRQ-1:0]                  irq_q;

  assign synced = sync_q[SYNC_STAGES-1];

  // IRQ synchroniser and history keep tracking through CPU reset so held lines give no edge
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
      s_d    <= '0;
      irq_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ext_irq};
      s_d    <= synced;
      irq_q  <= cpu_rstn ? (synced & ~(s_d & IRQ_EDGE)) : '0;
    end
  end

  always_comb begin
    intisr                = '0;
    intisr[NUM_IRQ-1:0]   = irq_q;
  end

endmodule

// File: tb/tb_cm3_sys_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for cm3_sys_ctrl: two instances (lockup reset on/off) against a
// cycle-level behavioural model, plus directed literal checks at key points.
module tb_cm3_sys_ctrl;

  localparam int unsigned NI  = 16;
  localparam int unsigned SS  = 2;
  localparam int unsigned POR = 16;
  localparam int unsigned SYS = 8;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          sysresetreq = 1'b0;
  logic          lockup = 1'b0;
  logic          req = 1'b0;
  logic [NI-1:0] ext_irq = '0;

  logic          cpu_rstn_o [2];
  logic [1:0]    cause_o    [2];
  logic          ack_o      [2];
  logic [239:0]  intisr_o   [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cm3_sys_ctrl #(
    .NUM_IRQ(NI), .SYNC_STAGES(SS), .IRQ_EDGE(16'h0001), .POR_CYCLES(POR),
    .SYSRST_CYCLES(SYS), .DBG_ACK_DLY(4), .LOCKUP_RST(1'b1)
  ) u_dut (
    .clk(clk), .rstn(rstn), .sysresetreq(sysresetreq), .lockup(lockup),
    .cdbg_pwr_up_req(req), .cdbg_pwr_up_ack(ack_o[0]), .ext_irq(ext_irq),
    .intisr(intisr_o[0]), .cpu_rstn(cpu_rstn_o[0]), .rst_cause(cause_o[0])
  );

  cm3_sys_ctrl #(
    .NUM_IRQ(NI), .SYNC_STAGES(SS), .IRQ_EDGE(16'h0000), .POR_CYCLES(POR),
    .SYSRST_CYCLES(SYS), .DBG_ACK_DLY(1), .LOCKUP_RST(1'b0)
  ) u_dut_nl (
    .clk(clk), .rstn(rstn), .sysresetreq(sysresetreq), .lockup(lockup),
    .cdbg_pwr_up_req(req), .cdbg_pwr_up_ack(ack_o[1]), .ext_irq(ext_irq),
    .intisr(intisr_o[1]), .cpu_rstn(cpu_rstn_o[1]), .rst_cause(cause_o[1])
  );

  function automatic int dly_of(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic bit lk_of(input int i);
    return (i == 0);
  endfunction

  function automatic logic [NI-1:0] edge_of(input int i);
    return (i == 0) ? 16'h0001 : 16'h0000;
  endfunction

  task automatic check(input string nm, input logic [239:0] act, input logic [239:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
    end
  endtask

  // Model: edge index since release, reset windows as [start, start+len), IRQ sample history
  int            n = 0;
  bit            m_cpu   [2];
  int            m_start [2];
  int            m_len   [2];
  bit            m_need  [2];
  logic [1:0]    m_cause [2];
  int            run_len = 0;
  logic [NI-1:0] hist    [SS+2];
  logic [NI-1:0] m_irq   [2];

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      n       = 0;
      run_len = 0;
      for (int k = 0; k < SS + 2; k++) hist[k] = '0;
      for (int i = 0; i < 2; i++) begin
        m_cpu[i]   = 1'b0;
        m_start[i] = 0;
        m_len[i]   = POR;
        m_need[i]  = 1'b0;
        m_cause[i] = 2'b00;
        m_irq[i]   = '0;
      end
    end else begin
      n++;
      for (int k = SS + 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = ext_irq;
      run_len = req ? run_len + 1 : 0;
      for (int i = 0; i < 2; i++) begin
        for (int b = 0; b < NI; b++) begin
          if (!m_cpu[i])         m_irq[i][b] = 1'b0;
          else if (edge_of(i)[b]) m_irq[i][b] = hist[SS][b] && !hist[SS+1][b];
          else                   m_irq[i][b] = hist[SS][b];
        end
        if (!m_cpu[i]) begin
          if ((n - m_start[i] >= m_len[i]) && !(m_need[i] && sysresetreq)) m_cpu[i] = 1'b1;
        end else if (sysresetreq || (lk_of(i) && lockup)) begin
          m_cpu[i]   = 1'b0;
          m_start[i] = n;
          m_len[i]   = SYS;
          m_need[i]  = 1'b1;
          m_cause[i] = sysresetreq ? 2'b01 : 2'b10;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      check($sformatf("cpu_rstn%0d", i), 240'(cpu_rstn_o[i]), 240'(m_cpu[i]));
      check($sformatf("rst_cause%0d", i), 240'(cause_o[i]), 240'(m_cause[i]));
      check($sformatf("ack%0d", i), 240'(ack_o[i]), 240'(run_len >= dly_of(i)));
      check($sformatf("intisr%0d", i), intisr_o[i], 240'(m_irq[i]));
    end
  end

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #2;
  endtask

  initial begin
    #1 rstn = 1'b0;
    step(2);
    check("rst_cpu", 240'(cpu_rstn_o[0]), 240'(0));
    check("rst_ack", 240'(ack_o[0]), 240'(0));
    check("rst_irq", intisr_o[0], 240'(0));
    check("rst_cause", 240'(cause_o[0]), 240'(0));
    rstn = 1'b1;
    step(15);
    check("por_edge15", 240'(cpu_rstn_o[0]), 240'(0));
    step(1);
    check("por_edge16", 240'(cpu_rstn_o[0]), 240'(1));

    // debug handshake
    req = 1'b1;
    step(3);
    check("dbg_ack0_e3", 240'(ack_o[0]), 240'(0));
    check("dbg_ack1_e3", 240'(ack_o[1]), 240'(1));
    step(1);
    check("dbg_ack0_e4", 240'(ack_o[0]), 240'(1));
    req = 1'b0;
    step(1);
    check("dbg_drop", 240'(ack_o[0]), 240'(0));
    req = 1'b1;
    step(2);
    req = 1'b0;
    check("dbg_glitch", 240'(ack_o[0]), 240'(0));
    step(3);
    check("dbg_glitch_after", 240'(ack_o[0]), 240'(0));

    // IRQ edge (ch0) and level (ch1)
    ext_irq = 16'h0003;
    step(2);
    check("irq_e2", 240'(intisr_o[0][1:0]), 240'(0));
    step(1);
    check("irq_e3", 240'(intisr_o[0][1:0]), 240'(2'b11));
    step(1);
    check("irq_e4", 240'(intisr_o[0][1:0]), 240'(2'b10));
    check("irq_e4_lvl", 240'(intisr_o[1][1:0]), 240'(2'b11));
    step(6);
    ext_irq = '0;
    step(2);
    check("irq_drop2", 240'(intisr_o[0][1]), 240'(1));
    step(1);
    check("irq_drop3", 240'(intisr_o[0][1]), 240'(0));

    // sysresetreq 3 cycles
    sysresetreq = 1'b1;
    step(1);
    check("sr_low", 240'(cpu_rstn_o[0]), 240'(0));
    check("sr_cause", 240'(cause_o[0]), 240'(2'b01));
    step(2);
    sysresetreq = 1'b0;
    step(5);
    check("sr_e7", 240'(cpu_rstn_o[0]), 240'(0));
    step(1);
    check("sr_e8", 240'(cpu_rstn_o[0]), 240'(1));

    // sysresetreq held 20 cycles
    sysresetreq = 1'b1;
    step(20);
    check("srh_e19", 240'(cpu_rstn_o[1]), 240'(0));
    sysresetreq = 1'b0;
    step(1);
    check("srh_e20", 240'(cpu_rstn_o[1]), 240'(1));

    // lockup and sysresetreq together, then lockup alone
    lockup = 1'b1;
    sysresetreq = 1'b1;
    step(1);
    check("both_cause0", 240'(cause_o[0]), 240'(2'b01));
    lockup = 1'b0;
    sysresetreq = 1'b0;
    step(8);
    lockup = 1'b1;
    step(1);
    check("lk_cpu0", 240'(cpu_rstn_o[0]), 240'(0));
    check("lk_cause0", 240'(cause_o[0]), 240'(2'b10));
    check("lk_cpu1", 240'(cpu_rstn_o[1]), 240'(1));
    check("lk_cause1", 240'(cause_o[1]), 240'(2'b01));
    lockup = 1'b0;
    step(8);
    check("lk_release", 240'(cpu_rstn_o[0]), 240'(1));

    // IRQ lines held high across a CPU reset
    ext_irq = 16'h0003;
    sysresetreq = 1'b1;
    step(1);
    sysresetreq = 1'b0;
    step(7);
    check("hold_e7", intisr_o[0], 240'(0));
    step(1);
    check("hold_e8_cpu", 240'(cpu_rstn_o[0]), 240'(1));
    check("hold_e8_irq", intisr_o[0], 240'(0));
    step(1);
    check("hold_e9_irq0", intisr_o[0], 240'(16'h0002));
    check("hold_e9_irq1", intisr_o[1], 240'(16'h0003));
    step(3);
    check("hold_no_pulse", intisr_o[0], 240'(16'h0002));
    ext_irq = '0;

    // rstn asserted mid-SYSRST
    sysresetreq = 1'b1;
    req = 1'b1;
    step(3);
    check("mid_cause", 240'(cause_o[1]), 240'(2'b01));
    #1 rstn = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("mid_cpu%0d", i), 240'(cpu_rstn_o[i]), 240'(0));
      check($sformatf("mid_cause%0d", i), 240'(cause_o[i]), 240'(0));
      check($sformatf("mid_ack%0d", i), 240'(ack_o[i]), 240'(0));
      check($sformatf("mid_irq%0d", i), intisr_o[i], 240'(0));
    end
    sysresetreq = 1'b0;
    req = 1'b0;
    step(1);
    rstn = 1'b1;
    step(15);
    check("repor_e15", 240'(cpu_rstn_o[0]), 240'(0));
    step(1);
    check("repor_e16", 240'(cpu_rstn_o[0]), 240'(1));
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
